// File: rtl/fetch_pkg.sv
// Shared widths, FSM state encoding and buffer entry layout for the fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO of {pc, byte}; entry 0 is always the head.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_data,
    output logic [1:0]        count,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data
);

    fetch_entry_t entry_reg  [2];
    fetch_entry_t entry_next [2];
    fetch_entry_t new_entry;
    logic [1:0]   count_reg;
    logic         pop_ok;
    logic         push_ok;
    logic [1:0]   wr_idx;

    assign pop_ok    = pop && (count_reg != 2'd0);
    assign push_ok   = push && ((count_reg != 2'd2) || pop_ok);
    // After a pop everything slides down one slot, so the write slot moves with it.
    assign wr_idx    = count_reg - {1'b0, pop_ok};
    assign new_entry = '{pc: push_pc, data: push_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_comb begin
                entry_next[gi] = entry_reg[gi];
                if (push_ok && (wr_idx == 2'(gi))) begin
                    entry_next[gi] = new_entry;
                end else if (pop_ok) begin
                    entry_next[gi] = (gi == 0) ? entry_reg[1] : '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= 2'd0;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            count_reg    <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
            entry_reg[0] <= entry_next[0];
            entry_reg[1] <= entry_next[1];
        end
    end

    assign count     = count_reg;
    assign head_pc   = entry_reg[0].pc;
    assign head_data = entry_reg[0].data;

endmodule

// File: rtl/fetch_unit.sv
// Byte fetch engine: IDLE/RUN/HALT FSM, 5-bit PC and a 2-entry instruction buffer.
// Define FETCH_STAT_EN to add the 8-bit fetch_count push counter output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 5'd0,
    parameter logic [DATA_W-1:0] HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_STAT_EN
    output logic [7:0]        fetch_count,
`endif
    output logic              halted
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    // A redirect flushes the buffer, so it also suppresses the pop.
    assign pop  = ir_valid && ir_ready && !redirect;
    assign push = (state_reg == ST_RUN) && run && !redirect &&
                  ((count != 2'd2) || pop);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect) begin
            state_next = run ? ST_RUN : ST_IDLE;
            pc_next    = redirect_pc;
        end else begin
            case (state_reg)
                ST_IDLE: if (run) state_next = ST_RUN;
                ST_RUN: begin
                    if (!run) begin
                        state_next = ST_IDLE;
                    end else if (push && (mem_data == HALT_OP)) begin
                        state_next = ST_HALT;
                    end
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_IDLE;
            endcase
            if (push) begin
                pc_next = pc_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_pc   (pc_reg),
        .push_data (mem_data),
        .count     (count),
        .head_pc   (ir_pc),
        .head_data (ir_data)
    );

`ifdef FETCH_STAT_EN
    logic [7:0] fetch_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_reg <= 8'd0;
        end else if (push) begin
            fetch_count_reg <= fetch_count_reg + 8'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
`endif

    assign mem_addr = pc_reg;
    assign ir_valid = (count != 2'd0);
    assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 32x8 combinational memory model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       ir_valid;
    logic [7:0] ir_data;
    logic [4:0] ir_pc;
    logic       ir_ready;
    logic       redirect;
    logic [4:0] redirect_pc;
    logic       halted;
`ifdef FETCH_STAT_EN
    logic [7:0] fetch_count;
`endif

    logic [7:0] mem [32];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_STAT_EN
        .fetch_count (fetch_count),
`endif
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; run = 1'b0; ir_ready = rdy; redirect = 1'b0; redirect_pc = 5'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 8 && !ir_valid; n++) tick();
        check(tag, 32'(ir_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);

        // Reset state
        do_reset(1'b1);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(ir_data), 32'd0);
        check("rst_pc", 32'(ir_pc), 32'd0);

        // Streaming with ready held high
        run = 1'b1;
        wait_valid("stream_wait");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_data%0d", i), 32'(ir_data), 32'h10 + 32'(i));
            check($sformatf("stream_pc%0d", i), 32'(ir_pc), 32'(i));
            check($sformatf("stream_valid%0d", i), 32'(ir_valid), 32'd1);
            tick();
        end

        // Backpressure: buffer fills, PC stalls at 2
        do_reset(1'b0);
        run = 1'b1;
        repeat (5) tick();
        check("stall_addr", 32'(mem_addr), 32'd2);
        check("stall_data", 32'(ir_data), 32'h10);
        check("stall_pc", 32'(ir_pc), 32'd0);
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain_data%0d", i), 32'(ir_data), 32'h10 + 32'(i));
            check($sformatf("drain_valid%0d", i), 32'(ir_valid), 32'd1);
            tick();
        end

        // Redirect while full, with address wrap
        ir_ready = 1'b0;
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 5'd30;
        tick();
        redirect = 1'b0;
        check("redir_valid", 32'(ir_valid), 32'd0);
        check("redir_addr", 32'(mem_addr), 32'd30);
        ir_ready = 1'b1;
        tick();
        check("wrap_data30", 32'(ir_data), 32'h2E);
        check("wrap_pc30", 32'(ir_pc), 32'd30);
        tick();
        check("wrap_data31", 32'(ir_data), 32'h2F);
        check("wrap_pc31", 32'(ir_pc), 32'd31);
        tick();
        check("wrap_data0", 32'(ir_data), 32'h10);
        check("wrap_pc0", 32'(ir_pc), 32'd0);

        // Halt opcode at address 4
        mem[4] = 8'hFF;
        do_reset(1'b1);
        run = 1'b1;
        wait_valid("halt_wait");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("halt_data%0d", i), 32'(ir_data), (i == 4) ? 32'hFF : 32'h10 + 32'(i));
            check($sformatf("halt_flag%0d", i), 32'(halted), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        check("halt_addr", 32'(mem_addr), 32'd5);
        check("halt_drained", 32'(ir_valid), 32'd0);
        tick();
        check("halt_hold_addr", 32'(mem_addr), 32'd5);
        check("halt_hold_valid", 32'(ir_valid), 32'd0);
        check("halt_hold_flag", 32'(halted), 32'd1);
        redirect = 1'b1; redirect_pc = 5'd0;
        tick();
        redirect = 1'b0;
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_addr", 32'(mem_addr), 32'd0);
`ifdef FETCH_STAT_EN
        check("redir_keeps_count", 32'(fetch_count), 32'd5);
`endif
        tick();
        check("resume_valid", 32'(ir_valid), 32'd1);
        check("resume_data", 32'(ir_data), 32'h10);
        mem[4] = 8'h14;

        // Reset while full and halted
        mem[1] = 8'hFF;
        do_reset(1'b0);
        run = 1'b1;
        repeat (3) tick();
        check("full_halt_flag", 32'(halted), 32'd1);
        check("full_halt_valid", 32'(ir_valid), 32'd1);
`ifdef FETCH_STAT_EN
        check("full_halt_count", 32'(fetch_count), 32'd2);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(ir_valid), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
`ifdef FETCH_STAT_EN
        check("midrst_count", 32'(fetch_count), 32'd0);
`endif
        mem[1] = 8'h11;

`ifdef FETCH_STAT_EN
        // 300 pushes wrap the 8-bit counter to 44
        do_reset(1'b1);
        run = 1'b1;
        tick();
        repeat (300) tick();
        run = 1'b0;
        check("count_300", 32'(fetch_count), 32'd44);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 5'd0: PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 8'hFF: byte that stops fetching once captured.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  level enable; fetching is permitted while high.
REQ-006 mem_addr  output  5  read address driven to the 32x8 memory; equals PC.
REQ-007 mem_data  input  8  same-cycle combinational read data for mem_addr.
REQ-008 ir_valid  output  1  head buffer entry is valid.
REQ-009 ir_data  output  8  byte at head entry.
REQ-010 ir_pc  output  5  address the head byte was fetched from.
REQ-011 ir_ready  input  1  consumer accepts head when high with ir_valid.
REQ-012 redirect  input  1  one-cycle request to restart fetching at redirect_pc.
REQ-013 redirect_pc  input  5  new fetch address.
REQ-014 halted  output  1  high while FSM is in HALT.

Function
REQ-015 FSM states: IDLE, RUN, HALT; IDLE->RUN when run=1; RUN->IDLE when run=0; RUN->HALT on the cycle a pushed byte equals HALT_OP; HALT->RUN only on redirect.
REQ-016 Buffer: 2-entry FIFO of {pc[4:0], byte[7:0]}; head drives ir_pc/ir_data; ir_valid = (count != 0).
REQ-017 Push: in RUN with run=1, no redirect, and (count<2 or pop this cycle), capture {PC, mem_data} and set PC <= PC+1 modulo 32 (5'd31 wraps to 5'd0).
REQ-018 Pop: ir_valid && ir_ready removes head at the edge; output changes to next entry the following cycle.
REQ-019 Full with simultaneous pop: push still occurs; count stays 2; zero-cycle loss.
REQ-020 Empty with push: entry visible on ir_valid the next cycle (latency 1 from address to output).
REQ-021 Redirect has priority over push and pop: FIFO flushed (count=0), PC <= redirect_pc, no push that cycle, state -> RUN if run=1 else IDLE.
REQ-022 In IDLE and HALT: no push, PC held, pops still permitted so buffered bytes drain.
REQ-023 HALT_OP byte itself is pushed and delivered; bytes after it are not fetched.
REQ-024 mem_addr is always PC, including in IDLE/HALT.

Reset
REQ-025 rst=1 at an edge: state=IDLE, PC=RESET_PC, count=0, ir_valid=0, halted=0; overrides redirect, push, pop.
REQ-026 ir_data/ir_pc read 0 after reset; reset mid-operation discards all buffered entries.

Configuration
REQ-027 Macro FETCH_STAT_EN defined: adds output fetch_count[7:0], incremented on each push, wrapping 8'hFF->8'h00, cleared by rst, not cleared by redirect.
REQ-028 Macro undefined: fetch_count port and counter absent; all other behaviour identical.

Structure
REQ-029 Package fetch_pkg holds ADDR_W=5, DATA_W=8, state enum fetch_state_t, entry struct fetch_entry_t.
REQ-030 Sub-module fetch_fifo: 2-entry FIFO with push/pop/flush, count, head output; fetch_unit holds FSM and PC.

Verification
REQ-031 Memory 0..3 = 8'h10,8'h11,8'h12,8'h13, ir_ready=1, run=1 after reset -> ir_data 10,11,12,13 on consecutive cycles, ir_pc 0..3.
REQ-032 ir_ready=0 for 5 cycles -> count=2, PC stalls at 2, ir_data held 8'h10; release ready -> 10,11,12 delivered with no gap or duplicate.
REQ-033 redirect with redirect_pc=5'd30 while full -> next cycle ir_valid=0; then bytes from 30, 31, 0 (wrap) delivered.
REQ-034 Byte 8'hFF at address 4 -> bytes 0..4 delivered, halted=1, PC=5, no further pushes; redirect to 0 -> halted=0, fetching resumes.
REQ-035 rst asserted while full and in HALT -> next cycle ir_valid=0, halted=0, mem_addr=RESET_PC; with FETCH_STAT_EN fetch_count=0.
REQ-036 With FETCH_STAT_EN, 300 pushes from reset -> fetch_count=8'd44.
